// File: rtl/clock_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_gen_pkg
// Description : Shared states, default parameters and width helper for clock_gen.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DELAY   = 3'd1,
        ST_HIGH    = 3'd2,
        ST_LOW     = 3'd3,
        ST_STOPPED = 3'd4
    } state_t;

    localparam int c_DEFAULT_LATENCY     = 4;
    localparam int c_DEFAULT_HIGH_CYCLES = 50;
    localparam int c_DEFAULT_LOW_CYCLES  = 50;
    localparam int c_DEFAULT_CNT_W       = 16;

    // Wide enough to hold the largest value ever loaded into the phase counter.
    function automatic int phase_cnt_width(input int latency,
                                           input int high_cycles,
                                           input int low_cycles);
        int m;
        m = latency;
        if (high_cycles > m) m = high_cycles;
        if (low_cycles > m)  m = low_cycles;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : phase_counter
// Description : Loadable down-counter; o_done is high while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_dec,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/clock_gen.sv
`default_nettype none
// ============================================================================
// Module      : clock_gen
// Description : Programmable gated clock generator with edge strobes and a
//               wrapping rising-edge counter.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_gen
    import clock_gen_pkg::*;
#(
    parameter int LATENCY     = c_DEFAULT_LATENCY,
    parameter int HIGH_CYCLES = c_DEFAULT_HIGH_CYCLES,
    parameter int LOW_CYCLES  = c_DEFAULT_LOW_CYCLES,
    parameter int CNT_W       = c_DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic             clk_out,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] gen_count
);

    localparam int c_PH_W = phase_cnt_width(LATENCY, HIGH_CYCLES, LOW_CYCLES);
    localparam logic [c_PH_W-1:0] c_LOAD_LATENCY = c_PH_W'(LATENCY);
    localparam logic [c_PH_W-1:0] c_LOAD_HIGH    = c_PH_W'(HIGH_CYCLES - 1);
    localparam logic [c_PH_W-1:0] c_LOAD_LOW     = c_PH_W'(LOW_CYCLES - 1);

    generate
        if (HIGH_CYCLES < 1) begin : g_chk_high
            $error("clock_gen: HIGH_CYCLES must be at least 1");
        end
        if (LOW_CYCLES < 1) begin : g_chk_low
            $error("clock_gen: LOW_CYCLES must be at least 1");
        end
        if ((LATENCY < 0) || (LATENCY > 255)) begin : g_chk_latency
            $error("clock_gen: LATENCY must lie in 0..255");
        end
    endgenerate

    state_t            r_state;
    logic              w_load;
    logic [c_PH_W-1:0] w_load_val;
    logic              w_dec;
    logic              w_done;

    phase_counter #(
        .WIDTH (c_PH_W)
    ) u_phase_counter (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_value (w_load_val),
        .i_dec   (w_dec),
        .o_done  (w_done)
    );

    // DELAY always spends one arming cycle plus the loaded count, which gives
    // the 1+LATENCY start from IDLE and the single-cycle restart from STOPPED.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_load     = 1'b1;
                    w_load_val = c_LOAD_LATENCY;
                end
            end
            ST_STOPPED: begin
                if (en) begin
                    w_load     = 1'b1;
                    w_load_val = '0;
                end
            end
            ST_DELAY: begin
                if (w_done) begin
                    w_load     = 1'b1;
                    w_load_val = c_LOAD_HIGH;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_HIGH: begin
                if (w_done) begin
                    w_load     = 1'b1;
                    w_load_val = c_LOAD_LOW;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_LOW: begin
                if (w_done) begin
                    if (en) begin
                        w_load     = 1'b1;
                        w_load_val = c_LOAD_HIGH;
                    end
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            clk_out   <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
            gen_count <= '0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (en) r_state <= ST_DELAY;
                end
                ST_STOPPED: begin
                    if (en) r_state <= ST_DELAY;
                end
                ST_DELAY: begin
                    if (w_done) begin
                        r_state   <= ST_HIGH;
                        clk_out   <= 1'b1;
                        rise      <= 1'b1;
                        gen_count <= gen_count + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (w_done) begin
                        r_state <= ST_LOW;
                        clk_out <= 1'b0;
                        fall    <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (w_done) begin
                        if (en) begin
                            r_state   <= ST_HIGH;
                            clk_out   <= 1'b1;
                            rise      <= 1'b1;
                            gen_count <= gen_count + CNT_W'(1);
                        end else begin
                            r_state <= ST_STOPPED;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    clk_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_gen
// Description : Self-checking bench for clock_gen using an edge-time model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_a, en_b;
    logic        clk_out_a, rise_a, fall_a;
    logic [3:0]  gen_count_a;
    logic        clk_out_b, rise_b, fall_b;
    logic [15:0] gen_count_b;

    int vectors = 0;
    int miscompares = 0;
    int edge_n = 0;

    always #5 clk = ~clk;

    clock_gen #(.LATENCY(4), .HIGH_CYCLES(3), .LOW_CYCLES(2), .CNT_W(4)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .en        (en_a),
        .clk_out   (clk_out_a),
        .rise      (rise_a),
        .fall      (fall_a),
        .gen_count (gen_count_a)
    );

    clock_gen #(.LATENCY(0), .HIGH_CYCLES(50), .LOW_CYCLES(50), .CNT_W(16)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .en        (en_b),
        .clk_out   (clk_out_b),
        .rise      (rise_b),
        .fall      (fall_b),
        .gen_count (gen_count_b)
    );

    // Model state is expressed as edge times: when the pending rise is due and
    // where the current period started, not as a phase down-counter.
    typedef struct packed {
        int e;
        int rise_at;
        int last_rise;
        int count;
        bit pending;
        bit running;
        bit first;
        bit clk_o;
        bit rise;
        bit fall;
    } model_t;

    model_t ma, mb;

    function automatic model_t model_reset();
        model_t m;
        m = '0;
        m.first = 1'b1;
        return m;
    endfunction

    function automatic model_t step(model_t m_in, bit en, int lat, int hi, int lo, int cw);
        model_t m;
        int p;
        m = m_in;
        m.e = m.e + 1;
        m.rise = 1'b0;
        m.fall = 1'b0;
        if (m.running) begin
            p = m.e - m.last_rise;
            if (p == hi) begin
                m.clk_o = 1'b0;
                m.fall  = 1'b1;
            end else if (p == hi + lo) begin
                if (en) begin
                    m.clk_o = 1'b1;
                    m.rise  = 1'b1;
                    m.last_rise = m.e;
                    m.count = (m.count + 1) % (1 << cw);
                end else begin
                    m.running = 1'b0;
                end
            end
        end else if (m.pending) begin
            if (m.e == m.rise_at) begin
                m.pending = 1'b0;
                m.running = 1'b1;
                m.clk_o = 1'b1;
                m.rise  = 1'b1;
                m.last_rise = m.e;
                m.count = (m.count + 1) % (1 << cw);
            end
        end else if (en) begin
            m.pending = 1'b1;
            m.rise_at = m.e + 1 + (m.first ? lat : 0);
            m.first = 1'b0;
        end
        return m;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma = model_reset();
            mb = model_reset();
            edge_n = 0;
        end else begin
            ma = step(ma, en_a, 4, 3, 2, 4);
            mb = step(mb, en_b, 0, 50, 50, 16);
            edge_n = edge_n + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s @edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("a.clk_out",   32'(clk_out_a),   32'(ma.clk_o));
        check("a.rise",      32'(rise_a),      32'(ma.rise));
        check("a.fall",      32'(fall_a),      32'(ma.fall));
        check("a.gen_count", 32'(gen_count_a), 32'(ma.count));
        check("b.clk_out",   32'(clk_out_b),   32'(mb.clk_o));
        check("b.rise",      32'(rise_b),      32'(mb.rise));
        check("b.fall",      32'(fall_b),      32'(mb.fall));
        check("b.gen_count", 32'(gen_count_b), 32'(mb.count));
    end

    task automatic to_edge(input int k);
        int guard;
        guard = 0;
        while ((edge_n < k) && (guard < 2000)) begin
            @(negedge clk);
            guard++;
        end
        check("edge_sync", 32'(edge_n), 32'(k));
    endtask

    task automatic reset_and_release(input bit ea);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        en_a  = ea;
        en_b  = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before the test sequence ended");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_cnt, rise_cnt, d;
        reset = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.clk_out", 32'(clk_out_a), 0);
        check("reset.count",   32'(gen_count_a), 0);

        // Startup latency with en held high.
        reset = 1'b1; en_a = 1'b1; en_b = 1'b1;
        to_edge(5);  check("lat.pre_rise", 32'(clk_out_a), 0);
        to_edge(6);  check("lat.rise6", 32'(rise_a), 1);
                     check("lat.count1", 32'(gen_count_a), 1);
        to_edge(9);  check("lat.fall9", 32'(fall_a), 1);
                     check("lat.clk9", 32'(clk_out_a), 0);
        to_edge(11); check("lat.rise11", 32'(rise_a), 1);
                     check("lat.count2", 32'(gen_count_a), 2);
        to_edge(12); check("lat.high12", 32'(clk_out_a), 1);

        // Asynchronous reset while clk_out is high.
        reset = 1'b0;
        #2;
        check("areset.a_clk", 32'(clk_out_a), 0);
        check("areset.a_cnt", 32'(gen_count_a), 0);
        check("areset.b_clk", 32'(clk_out_b), 0);
        check("areset.b_cnt", 32'(gen_count_b), 0);

        // Stop and restart; latency is reapplied after the reset.
        repeat (2) @(negedge clk);
        reset = 1'b1; en_a = 1'b1;
        to_edge(5);  check("stop.pre_rise", 32'(clk_out_a), 0);
        to_edge(6);  check("stop.rise6", 32'(rise_a), 1);
        to_edge(7);  en_a = 1'b0;
        to_edge(9);  check("stop.fall9", 32'(fall_a), 1);
        to_edge(11); check("stop.no_rise11", 32'(rise_a), 0);
                     check("stop.low11", 32'(clk_out_a), 0);
        to_edge(19); check("stop.low19", 32'(clk_out_a), 0);
                     en_a = 1'b1;
        to_edge(20); check("stop.low20", 32'(clk_out_a), 0);
        to_edge(21); check("stop.rise21", 32'(rise_a), 1);
                     check("stop.count2", 32'(gen_count_a), 2);

        // Counter wrap on the 4-bit instance.
        reset_and_release(1'b1);
        to_edge(81); check("wrap.rise16", 32'(rise_a), 1);
                     check("wrap.count0", 32'(gen_count_a), 0);
        to_edge(86); check("wrap.rise17", 32'(rise_a), 1);
                     check("wrap.count1", 32'(gen_count_a), 1);

        // Random en on the small instance; default-length periods on the other.
        reset_and_release(1'b1);
        hi_cnt = 0;
        rise_cnt = 0;
        for (int k = 1; k <= 1100; k++) begin
            to_edge(k);
            if (k >= 2 && k <= 1001) begin
                hi_cnt   += int'(clk_out_b);
                rise_cnt += int'(rise_b);
            end
            if (k == 2) check("dflt.first_rise", 32'(rise_b), 1);
            if (k == 1002) check("dflt.count11", 32'(gen_count_b), 11);
            en_a = ($urandom_range(0, 3) != 0);
        end
        check("dflt.high_cycles", 32'(hi_cnt), 500);
        check("dflt.rises", 32'(rise_cnt), 10);

        // Random asynchronous resets landing mid-cycle.
        for (int r = 0; r < 4; r++) begin
            reset_and_release(1'b1);
            repeat ($urandom_range(30, 200)) begin
                @(negedge clk);
                en_a = ($urandom_range(0, 4) != 0);
            end
            d = $urandom_range(1, 7);
            if (d >= 5) d++;
            #(d);
            reset = 1'b0;
            @(negedge clk);
        end
        reset_and_release(1'b1);
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_gen.md
# clock_gen

Synthesizable programmable clock generator. Derives a slower gated clock from the system reference clock. Phase lengths and startup latency are set by parameters, and the block emits single-cycle edge strobes plus a wrapping edge counter. It sits at the top of a test or system harness and drives the clock input of downstream FSMs such as the serial BCD-to-Excess-3 converter.

## Interface
- LATENCY, 4: reference cycles of extra low time before the first rising edge after reset; range 0–255.
- HIGH_CYCLES, 50: reference cycles `clk_out` stays high per period; minimum 1.
- LOW_CYCLES, 50: reference cycles `clk_out` stays low per period; minimum 1.
- CNT_W, 16: width of `gen_count`.
- `clk` in 1: reference clock. There is one clock; all state changes occur on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `en` in 1: run request for the generated clock.
- `clk_out` out 1: generated clock. It is a registered output and never glitches.
- `rise` out 1: one-cycle strobe, high in the cycle in which `clk_out` becomes 1.
- `fall` out 1: one-cycle strobe, high in the cycle in which `clk_out` becomes 0.
- `gen_count` out CNT_W: number of rising edges of `clk_out`; wraps modulo 2^CNT_W.

## Operation
- States: IDLE (after reset), DELAY, HIGH, LOW, STOPPED.
- Reset (`reset`=0, asynchronous, including mid-phase):
  - state goes to IDLE;
  - `clk_out`, `rise`, `fall`, `gen_count` and the phase counter all go to 0.
- IDLE: at the first edge N that samples `en`=1:
  - if LATENCY>0, go to DELAY for LATENCY cycles;
  - if LATENCY=0, go directly to the start of HIGH;
  - either way, `clk_out` rises at edge N+1+LATENCY.
- HIGH:
  - `clk_out`=1 for exactly HIGH_CYCLES reference cycles, then falls and the state moves to LOW.
  - `en` is ignored during this phase.
- LOW:
  - `clk_out`=0 for exactly LOW_CYCLES cycles.
  - At the edge ending LOW, `en` is sampled:
    - 1: rise again and go to HIGH;
    - 0: go to STOPPED with `clk_out` held low.
- STOPPED: at the edge M that samples `en`=1, `clk_out` rises at M+1. LATENCY is not reapplied, since low time is already at least LOW_CYCLES.
- Only whole periods are generated. Deasserting `en` never truncates a high or low phase.
- `gen_count` increments by 1 in the same cycle `rise` is asserted, and wraps from all-ones to 0.
- `rise` and `fall` are never high in the same cycle. Each is high for exactly one reference cycle per edge.
- LATENCY applies only once after each reset.

## Timing
- All outputs are registered and change on the `clk` rising edge, except for the asynchronous reset.
- Period is HIGH_CYCLES+LOW_CYCLES reference cycles; duty cycle is HIGH_CYCLES/period.
- With defaults, period is 100 reference cycles at 50% duty.
- `en` to first rise:
  - from IDLE: 1+LATENCY cycles;
  - from STOPPED: 1 cycle;
  - during LOW: taken at the end of the current LOW phase.
- When reset is released, the first edge that can sample `en` is the first `clk` rising edge after `reset` goes to 1.

## Structure
- Shared package `clock_gen_pkg`:
  - state enum (IDLE, DELAY, HIGH, LOW, STOPPED);
  - default parameter constants;
  - phase-counter width function, clog2 of max(LATENCY, HIGH_CYCLES, LOW_CYCLES)+1.
- One sub-module, `phase_counter`: a loadable down-counter with a `done` flag used for DELAY, HIGH and LOW.
- FSM, output registers and `gen_count` live in `clock_gen`.
- Elaboration-time assertions enforce HIGH_CYCLES≥1 and LOW_CYCLES≥1.

## Test plan
- Reset, including assertion mid-HIGH:
  - apply `reset`=0 while `clk_out`=1;
  - required: `clk_out`, `rise`, `fall`, `gen_count` go to 0 immediately, without waiting for a `clk` edge.
- Startup latency (LATENCY=4, HIGH=3, LOW=2; `en`=1 sampled at edge 1):
  - required: `clk_out` rises at edge 6, falls at edge 9, rises at edge 11;
  - `rise` pulses at edges 6 and 11; `fall` pulses at edge 9;
  - `gen_count` reads 1 then 2.
- Stop and restart (same parameters):
  - drop `en` at edge 7;
  - required: fall at edge 9, low through edge 11, STOPPED at edge 11 with no rise;
  - re-raise `en` sampled at edge 20 -> rise at edge 21.
- Counter wrap (CNT_W=4): after 16 rises, `gen_count`=0; after 17 rises, `gen_count`=1.
- Reset mid-operation then release: LATENCY is reapplied, and the first rise occurs 1+LATENCY cycles after `en` is sampled.
- Defaults (LATENCY=0, `en` held 1 from reset release): first rise 1 cycle after the first sampling edge, then period 100 with high time exactly 50 cycles over 10 periods.
